kernel_mult_issuer: RTL and testbench

- Initiator side of the adder_en / adder_dataIn / adder_done handshake used by the convolution datapath.
- Accepts one kernel window of pixels and low-width weights, forms the per-tap products serially, and packs them onto the adder input bus.
- Fires the adder, holds the bus stable until the adder reports done, then presents the sum downstream with a valid/ready handshake.

---
 rtl/kernel_mult_issuer.sv | 159 +++++++++++++++
 tb/tb_kernel_mult_issuer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_mult_issuer.sv
// kernel_mult_issuer: initiator side of the adder_en / adder_dataIn / adder_done handshake.
// It latches one kernel window of pixels and weights and forms one tap product per cycle
// into a packed lane bus. It then fires the adder, keeps the bus frozen while the adder
// runs, and hands the sum downstream on a valid/ready handshake.
//
// Optional feature: define ADDER_TIMEOUT_EN to bound the WAIT state to TIMEOUT_CYCLES.
// On expiry the block returns out_data=0 with out_err=1.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   start         window request, sampled only in IDLE
//   start_ready   high exactly in IDLE
//   pixels_in     KERNEL_SIZE unsigned pixels, tap i in slice i
//   weights_in    KERNEL_SIZE unsigned weights, tap i in slice i
//   adder_en      one-cycle fire pulse to the adder
//   adder_dataIn  packed per-tap products, RW bits per lane
//   adder_done    adder completion pulse
//   adder_dataOut adder sum, valid with adder_done
//   out_valid     result available
//   out_ready     downstream accept
//   out_data      captured sum
//   out_err       timeout flag (0 unless ADDER_TIMEOUT_EN)
module kernel_mult_issuer #(
  parameter int unsigned KERNEL_SIZE    = 3,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned WEIGHT_WIDTH   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  start,
  output logic                                                  start_ready,
  input  logic [DATA_WIDTH*KERNEL_SIZE-1:0]                     pixels_in,
  input  logic [WEIGHT_WIDTH*KERNEL_SIZE-1:0]                   weights_in,
  output logic                                                  adder_en,
  output logic [(DATA_WIDTH+WEIGHT_WIDTH)*KERNEL_SIZE-1:0]      adder_dataIn,
  input  logic                                                  adder_done,
  input  logic [DATA_WIDTH+WEIGHT_WIDTH+KERNEL_SIZE-1:0]        adder_dataOut,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic [DATA_WIDTH+WEIGHT_WIDTH+KERNEL_SIZE-1:0]        out_data,
  output logic                                                  out_err
);

  localparam int unsigned RW   = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int unsigned SW   = RW + KERNEL_SIZE;
  localparam int unsigned IdxW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {StIdle, StMult, StIssue, StWait, StOut} state_e;

  state_e                  state_q;
  logic [IdxW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0]   pix_q  [KERNEL_SIZE];
  logic [WEIGHT_WIDTH-1:0] wgt_q  [KERNEL_SIZE];
  logic [RW-1:0]           lane_q [KERNEL_SIZE];
  logic                    adder_en_q;
  logic                    out_valid_q;
  logic [SW-1:0]           out_data_q;
  logic [RW-1:0]           product;

  // Both operands widened to RW, so the product cannot overflow.
  assign product = RW'(pix_q[idx_q]) * RW'(wgt_q[idx_q]);

`ifdef ADDER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] wait_cnt_q;
  logic            out_err_q;
  assign out_err = out_err_q;
`else
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      adder_en_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < int'(KERNEL_SIZE); i++) lane_q[i] <= '0;
`ifdef ADDER_TIMEOUT_EN
      wait_cnt_q  <= '0;
      out_err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            for (int i = 0; i < int'(KERNEL_SIZE); i++) begin
              pix_q[i] <= pixels_in[i*DATA_WIDTH +: DATA_WIDTH];
              wgt_q[i] <= weights_in[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
            idx_q   <= '0;
            state_q <= StMult;
          end
        end
        StMult: begin
          lane_q[idx_q] <= product;
          if (idx_q == IdxW'(KERNEL_SIZE - 1)) begin
            // Raised here so the pulse is visible for exactly the ISSUE cycle.
            adder_en_q <= 1'b1;
            state_q    <= StIssue;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StIssue: begin
          adder_en_q <= 1'b0;
`ifdef ADDER_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          state_q    <= StWait;
        end
        StWait: begin
          // Lanes are not touched here: the adder reads them combinationally.
          if (adder_done) begin
            out_data_q  <= adder_dataOut;
            out_valid_q <= 1'b1;
            state_q     <= StOut;
`ifdef ADDER_TIMEOUT_EN
            out_err_q   <= 1'b0;
          end else if (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            out_data_q  <= '0;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= StOut;
          end else begin
            wait_cnt_q  <= wait_cnt_q + 1'b1;
`endif
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
`ifdef ADDER_TIMEOUT_EN
            out_err_q   <= 1'b0;
`endif
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar i = 0; i < int'(KERNEL_SIZE); i++) begin : g_lane
    assign adder_dataIn[(i+1)*RW-1 -: RW] = lane_q[i];
  end

  assign start_ready = (state_q == StIdle);
  assign adder_en    = adder_en_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;

endmodule

// File: tb/tb_kernel_mult_issuer.sv
module tb_kernel_mult_issuer;
  localparam int K  = 3;
  localparam int D  = 8;
  localparam int W  = 1;
  localparam int RW = D + W;
  localparam int SW = RW + K;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            start_ready;
  logic [K*D-1:0]  pixels_in;
  logic [K*W-1:0]  weights_in;
  logic            adder_en;
  logic [K*RW-1:0] adder_dataIn;
  logic            adder_done;
  logic [SW-1:0]   adder_dataOut;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_data;
  logic            out_err;

  always #5 clk = ~clk;

  kernel_mult_issuer #(
    .KERNEL_SIZE   (K),
    .DATA_WIDTH    (D),
    .WEIGHT_WIDTH  (W),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_ready  (start_ready),
    .pixels_in    (pixels_in),
    .weights_in   (weights_in),
    .adder_en     (adder_en),
    .adder_dataIn (adder_dataIn),
    .adder_done   (adder_done),
    .adder_dataOut(adder_dataOut),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_err      (out_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [SW-1:0] data;
    logic          err;
  } exp_t;
  exp_t sb_q[$];

  function automatic logic [SW-1:0] ref_sum(input logic [K*D-1:0] p, input logic [K*W-1:0] w);
    logic [SW-1:0] s = '0;
    for (int i = 0; i < K; i++) s += SW'(p[i*D +: D]) * SW'(w[i*W +: W]);
    return s;
  endfunction

  // Sequential adder model: samples adder_en, answers K cycles later.
  logic          model_done = 1'b0;
  logic          stray_done = 1'b0;
  logic          no_resp    = 1'b0;
  logic          busy       = 1'b0;
  logic [SW-1:0] model_sum  = '0;
  int            acnt       = 0;

  function automatic logic [SW-1:0] lane_sum(input logic [K*RW-1:0] b);
    logic [SW-1:0] s = '0;
    for (int i = 0; i < K; i++) s += SW'(b[i*RW +: RW]);
    return s;
  endfunction

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (adder_en) begin
      busy <= 1'b1;
      acnt <= 0;
    end else if (busy) begin
      if (acnt == K - 1) begin
        busy <= 1'b0;
        if (!no_resp) begin
          model_done <= 1'b1;
          model_sum  <= lane_sum(adder_dataIn);
        end
      end else begin
        acnt <= acnt + 1;
      end
    end
  end

  assign adder_done    = model_done | stray_done;
  assign adder_dataOut = model_sum;

  // Scoreboard: pop on every accepted result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check_eq("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("out_data", out_data, e.data);
        check_eq("out_err", out_err, e.err);
      end
    end
  end

  // Bus stability and single-pulse fire from adder_en until adder_done.
  logic            armed = 1'b0;
  logic [K*RW-1:0] snap;
  logic            changed;
  int              en_cycles;

  always @(negedge clk) begin
    if (armed && start_ready) begin
      armed <= 1'b0;
    end else if (adder_en && !armed) begin
      armed     <= 1'b1;
      snap      <= adder_dataIn;
      changed   <= 1'b0;
      en_cycles <= 1;
    end else if (armed) begin
      if (adder_en) en_cycles <= en_cycles + 1;
      if (adder_dataIn !== snap) changed <= 1'b1;
      if (adder_done) begin
        check_eq("dataIn_stable", changed || (adder_dataIn !== snap), 0);
        check_eq("adder_en_once", en_cycles + (adder_en ? 1 : 0), 1);
        armed <= 1'b0;
      end
    end
  end

  // Caller is at a negedge; returns at the negedge after the start edge.
  task automatic send(input logic [K*D-1:0] p, input logic [K*W-1:0] w, input logic terr);
    int   t = 0;
    exp_t e;
    while (!start_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check_eq("start_ready_wait", start_ready, 1);
    pixels_in  = p;
    weights_in = w;
    start      = 1'b1;
    e.data     = terr ? '0 : ref_sum(p, w);
    e.err      = terr;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb_q.size() != 0 || !start_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check_eq("drain_timeout", sb_q.size(), 0);
  endtask

  task automatic measure_latency(input string tag);
    int lat = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check_eq(tag, lat, 2 * K + 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW-1:0] rec;
    int            t;
    logic          anyv;

    rst        = 1'b1;
    start      = 1'b0;
    pixels_in  = '0;
    weights_in = '0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_start_ready", start_ready, 1);
    check_eq("rst_adder_en", adder_en, 0);
    check_eq("rst_dataIn", adder_dataIn, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_err", out_err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic window and latency.
    send({8'd30, 8'd20, 8'd10}, 3'b101, 1'b0);
    measure_latency("latency");
    check_eq("lanes_10_0_30", adder_dataIn, {9'd30, 9'd0, 9'd10});
    @(posedge clk);
    #1;
    check_eq("valid_drop", out_valid, 0);
    check_eq("lanes_kept", adder_dataIn, {9'd30, 9'd0, 9'd10});
    drain();

    // Full-scale, no truncation.
    @(negedge clk);
    send({8'd255, 8'd255, 8'd255}, 3'b111, 1'b0);
    drain();

    // Backpressure; starts during OUT are ignored.
    out_ready = 1'b0;
    @(negedge clk);
    send({8'd7, 8'd6, 8'd5}, 3'b011, 1'b0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq("bp_valid_seen", out_valid, 1);
    check_eq("bp_data", out_data, 11);
    rec = out_data;
    for (int i = 0; i < 5; i++) begin
      start     = 1'b1;
      pixels_in = {8'd99, 8'd99, 8'd99};
      @(negedge clk);
      check_eq("bp_hold_valid", out_valid, 1);
      check_eq("bp_hold_data", out_data, rec);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_released", out_valid, 0);
    check_eq("bp_idle", start_ready, 1);
    send({8'd1, 8'd1, 8'd1}, 3'b111, 1'b0);
    drain();

    // Reset during WAIT, then a stray done.
    @(negedge clk);
    send({8'd6, 8'd5, 8'd4}, 3'b111, 1'b0);
    t = 0;
    while (!adder_en && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("fire_seen", adder_en, 1);
    @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    check_eq("mid_rst_start_ready", start_ready, 1);
    check_eq("mid_rst_adder_en", adder_en, 0);
    check_eq("mid_rst_dataIn", adder_dataIn, 0);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_out_data", out_data, 0);
    check_eq("mid_rst_out_err", out_err, 0);
    @(negedge clk);
    rst  = 1'b0;
    anyv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      stray_done = (i == 6);
      @(negedge clk);
      if (out_valid) anyv = 1'b1;
    end
    stray_done = 1'b0;
    check_eq("stray_done_ignored", anyv, 0);
    send({8'd3, 8'd2, 8'd1}, 3'b111, 1'b0);
    drain();

`ifdef ADDER_TIMEOUT_EN
    // Adder never answers.
    no_resp = 1'b1;
    @(negedge clk);
    send({8'd9, 8'd9, 8'd9}, 3'b111, 1'b1);
    measure_latency("timeout_latency");
    check_eq("timeout_err", out_err, 1);
    drain();
    no_resp = 1'b0;
    @(negedge clk);
    send({8'd2, 8'd2, 8'd2}, 3'b111, 1'b0);
    drain();
`endif

    repeat (3) @(negedge clk);
    check_eq("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
